// File: rtl/fetch_ctrl.sv
// F-stage sequencer: drives the PC register load, the instruction-memory
// request/ack handshake, the stall hold buffer and the illegal-fetch trap.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic        pc_we,
  output logic [31:0] pc_next,
  input  logic        stall_in,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        fetch_err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned EXT_W  = ADDR_W + 1;

  // Range bounds widened by one bit so the upper limit cannot wrap.
  localparam logic [EXT_W-1:0] PC_LO = EXT_W'(RESET_PC);
  localparam logic [EXT_W-1:0] PC_HI = EXT_W'(RESET_PC) + (EXT_W'(IMEM_WORDS) << 2);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]  buf_q, buf_d;
  logic               err_q, err_d;

  logic [ADDR_W-1:0]  cand_pc;
  logic               cand_bad;
  logic               advance;

  // Candidate next PC by priority: live redirect, pending redirect, sequential.
  always_comb begin
    if (redir_valid) begin
      cand_pc = redir_target;
    end else if (pend_vld_q) begin
      cand_pc = pend_q;
    end else begin
      cand_pc = pc_cur + ADDR_W'(4);
    end
    cand_bad = (cand_pc[1:0] != 2'b00)
            || (EXT_W'(cand_pc) < PC_LO)
            || (EXT_W'(cand_pc) >= PC_HI);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    buf_d       = buf_q;
    err_d       = err_q;
    advance     = 1'b0;
    pc_we       = 1'b0;
    pc_next     = pc_cur;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr = imem_rdata;
          if (stall_in) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            instr_valid = 1'b1;
            advance     = 1'b1;
          end
        end
      end
      HOLD: begin
        instr = buf_q;
        if (!stall_in) begin
          instr_valid = 1'b1;
          advance     = 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // An illegal target suppresses the PC write but not the delivered instruction.
    if (advance) begin
      pend_vld_d = 1'b0;
      if (cand_bad) begin
        err_d   = 1'b1;
        state_d = ERR;
      end else begin
        pc_we   = 1'b1;
        pc_next = cand_pc;
        state_d = FETCH;
      end
    end else if (redir_valid) begin
      pend_vld_d = 1'b1;
      pend_d     = redir_target;
    end
  end

  assign imem_addr = pc_cur;
  assign fetch_err = err_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the PC register and the instruction-memory port in the fetch (F) stage.
- Decides each cycle whether the PC register loads, and what value it loads: pc+4, a branch/jump redirect, or a redirect held from an earlier cycle.
- Runs a variable-latency instruction-memory request/acknowledge handshake.
- Buffers a fetched instruction while the hazard unit stalls F, and traps an illegal fetch address.

Parameters:
- RESET_PC, 32'h0000_3000, byte address of the first instruction; the PC register resets to this value.
- IMEM_WORDS, 4096, instruction-memory depth in words; the legal range is [RESET_PC, RESET_PC + 4*IMEM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- pc_cur  in  32  current byte address from the PC register.
- pc_we  out  1  1 = PC register loads pc_next on this edge.
- pc_next  out  32  next PC; equals pc_cur whenever pc_we=0.
- stall_in  in  1  hazard-unit stall for F/D; 1 = F/D must not accept an instruction.
- redir_valid  in  1  one-cycle pulse from D-stage branch/jump resolution.
- redir_target  in  32  redirect byte address; qualified by redir_valid.
- imem_req  out  1  instruction fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; equals pc_cur.
- imem_ack  in  1  fetch complete; imem_rdata is valid in this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  1 = F/D register latches instr this cycle.
- instr  out  32  instruction to F/D.
- fetch_err  out  1  sticky flag: misaligned or out-of-range next PC.

Behaviour:
- Reset values (asserted while reset=0):
  - state=BOOT, imem_req=0, pc_we=0, instr_valid=0, instr=0, fetch_err=0.
  - pending-redirect register empty; pc_next=pc_cur.
- States and transitions:
  - BOOT: one cycle after reset deasserts; no request issued; moves to FETCH.
  - FETCH: imem_req=1, imem_addr=pc_cur. Waits any number of cycles for imem_ack.
    - Ack with stall_in=0: instr=imem_rdata passes through combinationally, instr_valid=1, pc_we=1. Stays in FETCH; a new request for the updated PC starts next cycle.
    - Ack with stall_in=1: imem_rdata goes into the hold buffer, pc_we=0, moves to HOLD.
    - imem_ack is ignored outside FETCH.
  - HOLD: imem_req=0, instr=buffer, instr_valid=!stall_in.
    - When stall_in=0: pc_we=1 and moves to FETCH in the same cycle.
    - The buffer is never overwritten while in HOLD.
  - ERR: imem_req=0, pc_we=0, instr_valid=0, fetch_err=1. Exits only through reset.
- Next-PC priority, evaluated in cycles with pc_we=1:
  1. redir_valid=1 this cycle: pc_next=redir_target.
  2. Pending register full: pc_next=pending target.
  3. Otherwise: pc_next=pc_cur+4, modulo 2^32, no carry out.
- Redirect capture:
  - redir_valid in a cycle with pc_we=0 writes the pending register.
  - A newer redirect overwrites an older pending one.
  - The pending register clears on the edge where its value, or a newer redirect, is loaded.
  - The instruction in flight when a redirect arrives is the delay slot. It is still delivered, not squashed.
- Address check, applied to the chosen pc_next in every pc_we=1 cycle:
  - Illegal if pc_next[1:0]!=0, pc_next<RESET_PC, or pc_next>=RESET_PC+4*IMEM_WORDS.
  - On an illegal value: pc_we is forced to 0, fetch_err sets, state goes to ERR.
  - instr_valid for the instruction delivered in that cycle stays 1.
- Simultaneous events:
  - Ack, stall_in=1 and redir_valid in the same cycle: instruction goes to the buffer, redirect goes to pending, state goes to HOLD.
  - Redirect with stall_in=0 in HOLD: applied directly.
- Reset mid-operation: imem_req drops combinationally; any in-flight ack after reset is ignored because the block is in BOOT.
- No further latency beyond the memory: zero extra cycles from ack to instr_valid when not stalled.

Test Plan:
- Reset release with imem_ack high every cycle, memory returning 0x24010001, 0x24020002, 0x24030003:
  - No request in the BOOT cycle.
  - imem_addr sequence 0x3000, 0x3004, 0x3008; pc_we=1 each cycle; instr_valid every cycle.
- imem_ack delayed 3 cycles:
  - imem_req and imem_addr=0x3000 stay stable for 3 cycles.
  - pc_we=0 and instr_valid=0 until ack.
- Ack at 0x3004 with stall_in=1 for 2 cycles, rdata=0x8C080000:
  - HOLD for 2 cycles; instr=0x8C080000 with instr_valid=0.
  - Stall drops: instr_valid=1, pc_next=0x3008.
- redir_valid with target 0x3040 during a stalled cycle, then stall releases:
  - pending register holds 0x3040.
  - On release: delay-slot instruction delivered, pc_next=0x3040, pending cleared.
- Redirect to 0x3002 (misaligned), and separately to 0x7000 with IMEM_WORDS=4096:
  - PC not written; fetch_err=1 and stays 1.
  - No further imem_req.
- reset driven low while imem_req=1 mid-wait:
  - imem_req drops immediately.
  - A late ack after release produces no instr_valid.
  - Fetch restarts at 0x3000 after BOOT.
